branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the EX-stage branch decision logic: resolves conditional branches from funct3 and ALU flags, and adds a bimodal branch history table (BHT) of saturating counters.
- IF reads a prediction by PC. EX resolves the branch, flags a mispredict and trains the table.
- Keeps branch and mispredict statistics counters for cache and pipeline performance studies.

Parameters:
- BHT_ENTRIES, 64, number of table entries; power of two, 2..1024.
- PC_WIDTH, 32, PC width.
- CTR_BITS, 2, saturating counter width, 1..4.
- CTR_INIT, 1, counter value loaded on reset (weakly not-taken for 2 bits).
- STAT_WIDTH, 32, width of the statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- if_pc  in  PC_WIDTH  fetch PC to predict.
- pred_taken  out  1  prediction for if_pc: counter MSB.
- ex_pc  in  PC_WIDTH  PC of the instruction in EX.
- ex_valid  in  1  EX holds a real instruction (not a bubble).
- ex_stall  in  1  EX is held this cycle; suppresses training and statistics.
- ex_branch  in  1  Branch control bit of the EX instruction.
- ex_funct3  in  3  branch funct3.
- ex_zero  in  1  ALU zero flag.
- ex_sign  in  1  ALU compare result (signed or unsigned per funct3; the ALU selects).
- ex_pred_taken  in  1  prediction carried down the pipe with the instruction.
- branch_taken  out  1  resolved direction.
- mispredict  out  1  resolved direction differs from prediction; pipeline flushes IF/ID.
- branch_count  out  STAT_WIDTH  trained branches since reset.
- mispredict_count  out  STAT_WIDTH  mispredicts since reset.

Behaviour:
- Index: idx = pc[$clog2(BHT_ENTRIES)+1:2]. Bits [1:0] are ignored.
- Prediction:
  - Combinational read of the table at idx(if_pc): pred_taken = ctr[CTR_BITS-1].
  - No bypass: an update in the same cycle to the same index becomes visible the next cycle.
- Resolution is combinational over all inputs (full sensitivity, no latches), with resolve = ex_valid & ex_branch:
  - BEQ → zero.
  - BNE → ~zero.
  - BLT/BLTU → sign.
  - BGE/BGEU → ~sign.
  - funct3 010/011 → illegal, branch_taken = 0.
  - branch_taken = 0 whenever resolve = 0.
- Legal branch: legal = resolve & funct3 is not 010/011.
- mispredict = legal & (branch_taken != ex_pred_taken). It is combinational and asserts even while ex_stall = 1; the flush logic qualifies it.
- Training, at the clock edge when legal & ~ex_stall:
  - ctr[idx(ex_pc)] saturates up if taken, saturates down if not.
  - At all-ones and taken, the counter holds; at zero and not taken, it holds.
- Statistics, on the same condition as training:
  - branch_count increments by 1.
  - mispredict_count increments by 1 when mispredict = 1.
  - Both counters wrap modulo 2^STAT_WIDTH.
- Reset:
  - While reset = 1, all table entries load CTR_INIT and both statistics counters load 0 at the edge.
  - Reset dominates any simultaneous training.
  - Combinational outputs follow their inputs during reset; pred_taken reflects CTR_INIT from the first cycle after reset.
- Reset mid-operation: an in-flight branch in EX is not trained; the table is cleared in one cycle, with no sweep FSM.
- Simultaneous IF read and EX write to the same index: IF sees the old value; EX writes the new value.
- Aliasing: distinct PCs with equal idx share an entry. This is by design, with no tags.

Decomposition:
- Shared package/header:
  - FUNCT3_BEQ/BNE/BLT/BGE/BLTU/BGEU constants (existing constants file).
  - Localparam IDX_W = $clog2(BHT_ENTRIES).
  - Counter max/min constants.
- One natural sub-module, sat_counter: a parametrised CTR_BITS up/down saturating counter with enable and synchronous load, instantiated BHT_ENTRIES times via generate.
- Resolution logic stays inline.

Test Plan:
1. Reset, then if_pc = 0x100 → pred_taken = 0 (CTR_INIT = 1), branch_count = 0, mispredict_count = 0.
2. Train BEQ at ex_pc 0x100 with zero = 1, ex_pred_taken = 0, twice:
   - Both cycles: mispredict = 1.
   - Counter goes 1→2→3; pred_taken for 0x100 = 1 from the cycle after the first update.
   - Counts end at 2 and 2.
3. Saturation: taken BNE at ex_pc 0x200 (zero = 0) five times → counter holds at 3. Then one not-taken → counter = 2, pred_taken still 1.
4. Aliasing, same-cycle read/write and stall:
   - if_pc = 0x100 and ex_pc = 0x200 train in the same cycle (BHT_ENTRIES = 64, equal index) → pred_taken shows the old value that cycle and the new value the next cycle.
   - ex_stall = 1 → no counter change.
5. Illegal and unqualified branches:
   - funct3 = 3'b010 with ex_branch = 1 → branch_taken = 0, mispredict = 0, no training, branch_count unchanged.
   - ex_valid = 0 → same result.
6. Reset during training (reset = 1 with a legal branch in EX) → all entries = CTR_INIT and counts = 0 next cycle.
   - Statistics wrap with STAT_WIDTH = 4: 16 trained branches → branch_count = 0.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: branch funct3 encodings and saturating-counter limits
package branch_predict_unit_pkg;
    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;
    localparam int CTR_MIN = 0;

    function automatic int ctr_max(input int bits);
        return (1 << bits) - 1;
    endfunction
endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// sat_counter: up/down saturating counter with enable and synchronous load
module sat_counter
    import branch_predict_unit_pkg::*;
#(
    parameter int W = 2,
    parameter logic [W-1:0] INIT = 1
) (
    input  logic         clock,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] MAX = W'(ctr_max(W));
    localparam logic [W-1:0] MIN = W'(CTR_MIN);

    always_ff @(posedge clock) begin
        if (load)
            q <= INIT;
        else if (en)
            q <= up ? (q == MAX ? q : q + 1'b1) : (q == MIN ? q : q - 1'b1);
    end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: EX branch resolution plus a bimodal BHT predictor with
// branch/mispredict statistics.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int PC_WIDTH    = 32,
    parameter int CTR_BITS    = 2,
    parameter int CTR_INIT    = 1,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PC_WIDTH-1:0]   if_pc,
    output logic                  pred_taken,
    input  logic [PC_WIDTH-1:0]   ex_pc,
    input  logic                  ex_valid,
    input  logic                  ex_stall,
    input  logic                  ex_branch,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_zero,
    input  logic                  ex_sign,
    input  logic                  ex_pred_taken,
    output logic                  branch_taken,
    output logic                  mispredict,
    output logic [STAT_WIDTH-1:0] branch_count,
    output logic [STAT_WIDTH-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0]    if_idx, ex_idx;
    logic [CTR_BITS-1:0] ctr [BHT_ENTRIES];
    logic                legal, cond, train;
    logic                unused_pc;

    assign if_idx    = if_pc[IDX_W+1:2];
    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign unused_pc = ^{if_pc[PC_WIDTH-1:IDX_W+2], if_pc[1:0], ex_pc[PC_WIDTH-1:IDX_W+2], ex_pc[1:0]};
    assign pred_taken = ctr[if_idx][CTR_BITS-1];

    // funct3 010/011 are not branches, so they never resolve or train
    always_comb begin
        legal = ex_valid & ex_branch & (ex_funct3[2:1] != 2'b01);
        cond  = ex_funct3 == FUNCT3_BEQ ? ex_zero :
                ex_funct3 == FUNCT3_BNE ? ~ex_zero :
                (ex_funct3 == FUNCT3_BLT || ex_funct3 == FUNCT3_BLTU) ? ex_sign :
                (ex_funct3 == FUNCT3_BGE || ex_funct3 == FUNCT3_BGEU) ? ~ex_sign : 1'b0;
        branch_taken = legal & cond;
        mispredict   = legal & (branch_taken != ex_pred_taken);
        train        = legal & ~ex_stall;
    end

    for (genvar g = 0; g < BHT_ENTRIES; g++) begin : g_bht
        sat_counter #(
            .W    (CTR_BITS),
            .INIT (CTR_BITS'(CTR_INIT))
        ) u_ctr (
            .clock (clock),
            .load  (reset),
            .en    (train && ex_idx == IDX_W'(g)),
            .up    (branch_taken),
            .q     (ctr[g])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (train) begin
            branch_count <= branch_count + 1'b1;
            if (mispredict)
                mispredict_count <= mispredict_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed plus random stimulus against a table-of-ints
// reference model of the predictor and statistics.
module tb_branch_predict_unit;
    localparam int ENT = 64;
    localparam int SW  = 4;

    logic          clock = 0;
    logic          reset;
    logic [31:0]   if_pc, ex_pc;
    logic          pred_taken, ex_valid, ex_stall, ex_branch, ex_zero, ex_sign, ex_pred_taken;
    logic [2:0]    ex_funct3;
    logic          branch_taken, mispredict;
    logic [SW-1:0] branch_count, mispredict_count;

    int bht [ENT];
    int bc, mc;
    int checks = 0;
    int failures = 0;

    branch_predict_unit #(
        .BHT_ENTRIES (ENT),
        .PC_WIDTH    (32),
        .CTR_BITS    (2),
        .CTR_INIT    (1),
        .STAT_WIDTH  (SW)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .ex_pc            (ex_pc),
        .ex_valid         (ex_valid),
        .ex_stall         (ex_stall),
        .ex_branch        (ex_branch),
        .ex_funct3        (ex_funct3),
        .ex_zero          (ex_zero),
        .ex_sign          (ex_sign),
        .ex_pred_taken    (ex_pred_taken),
        .branch_taken     (branch_taken),
        .mispredict       (mispredict),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clock = ~clock;

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % ENT);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic b, input logic [2:0] f3, input logic z,
                         input logic s, input logic pt, input logic st,
                         input logic [31:0] epc, input logic [31:0] ipc);
        ex_valid = v; ex_branch = b; ex_funct3 = f3; ex_zero = z; ex_sign = s;
        ex_pred_taken = pt; ex_stall = st; ex_pc = epc; if_pc = ipc;
    endtask

    // Inputs are driven at posedge+1; outputs checked at negedge; model steps at posedge.
    task automatic cycle();
        bit legal, taken;
        legal = ex_valid && ex_branch && !(ex_funct3 == 3'd2 || ex_funct3 == 3'd3);
        case (ex_funct3)
            3'd0:       taken = ex_zero;
            3'd1:       taken = !ex_zero;
            3'd4, 3'd6: taken = ex_sign;
            3'd5, 3'd7: taken = !ex_sign;
            default:    taken = 0;
        endcase
        taken = legal && taken;
        @(negedge clock);
        chk("pred_taken", 32'(pred_taken), 32'(bht[idx(if_pc)] >= 2));
        chk("branch_taken", 32'(branch_taken), 32'(taken));
        chk("mispredict", 32'(mispredict), 32'(legal && (taken != ex_pred_taken)));
        chk("branch_count", 32'(branch_count), 32'(bc));
        chk("mispredict_count", 32'(mispredict_count), 32'(mc));
        @(posedge clock);
        if (reset) begin
            foreach (bht[i]) bht[i] = 1;
            bc = 0; mc = 0;
        end else if (legal && !ex_stall) begin
            bht[idx(ex_pc)] = taken ? (bht[idx(ex_pc)] == 3 ? 3 : bht[idx(ex_pc)] + 1)
                                    : (bht[idx(ex_pc)] == 0 ? 0 : bht[idx(ex_pc)] - 1);
            bc = (bc + 1) % (1 << SW);
            if (taken != ex_pred_taken) mc = (mc + 1) % (1 << SW);
        end
        #1;
    endtask

    initial begin
        reset = 1;
        drive(0, 0, 3'd0, 0, 0, 0, 0, 32'h0, 32'h100);
        repeat (2) @(posedge clock);
        foreach (bht[i]) bht[i] = 1;
        bc = 0; mc = 0;
        #1 reset = 0;

        // reset state
        cycle();
        chk("reset_pred", 32'(pred_taken), 32'd0);
        chk("reset_bc", 32'(branch_count), 32'd0);

        // BEQ taken twice at 0x100, predicted not-taken
        drive(1, 1, 3'd0, 1, 0, 0, 0, 32'h100, 32'h100);
        cycle();
        cycle();
        drive(0, 0, 3'd0, 0, 0, 0, 0, 32'h0, 32'h100);
        cycle();
        chk("beq_pred", 32'(pred_taken), 32'd1);
        chk("beq_bc", 32'(branch_count), 32'd2);
        chk("beq_mc", 32'(mispredict_count), 32'd2);

        // saturation: 5 taken BNE at 0x200, then one not-taken
        drive(1, 1, 3'd1, 0, 0, 1, 0, 32'h200, 32'h200);
        repeat (5) cycle();
        drive(1, 1, 3'd1, 1, 0, 1, 0, 32'h200, 32'h200);
        cycle();
        drive(0, 0, 3'd0, 0, 0, 0, 0, 32'h0, 32'h200);
        cycle();
        chk("sat_pred", 32'(pred_taken), 32'd1);

        // alias + same-cycle read/write: old value visible, new value next cycle
        drive(1, 1, 3'd0, 0, 0, 1, 0, 32'h200, 32'h100);
        cycle();
        drive(0, 0, 3'd0, 0, 0, 0, 0, 32'h0, 32'h100);
        cycle();
        chk("alias_pred", 32'(pred_taken), 32'd0);

        // stall: mispredict visible, no training
        drive(1, 1, 3'd0, 1, 0, 0, 1, 32'h100, 32'h100);
        cycle();
        drive(0, 0, 3'd0, 0, 0, 0, 0, 32'h0, 32'h100);
        cycle();

        // illegal funct3 and bubble
        drive(1, 1, 3'd2, 1, 1, 1, 0, 32'h100, 32'h100);
        cycle();
        drive(1, 1, 3'd3, 0, 1, 1, 0, 32'h100, 32'h100);
        cycle();
        drive(0, 1, 3'd0, 1, 0, 0, 0, 32'h100, 32'h100);
        cycle();

        // reset with a legal branch in EX, then sweep every entry
        reset = 1;
        drive(1, 1, 3'd0, 1, 0, 0, 0, 32'h100, 32'h100);
        cycle();
        reset = 0;
        for (int i = 0; i < ENT; i++) begin
            drive(0, 0, 3'd0, 0, 0, 0, 0, 32'h0, 32'(i * 4));
            cycle();
        end

        // statistics wrap at 2^SW
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 3'd4, 0, 1, 1, 0, 32'(i * 4), 32'h0);
            cycle();
        end
        drive(0, 0, 3'd0, 0, 0, 0, 0, 32'h0, 32'h0);
        cycle();
        chk("wrap_bc", 32'(branch_count), 32'd0);

        // random traffic on a narrow PC range to force aliasing
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 4) == 0,
                  $urandom & 32'h1FF, $urandom & 32'h1FF);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
